lab2_proc_int_muldiv_iter: RTL and testbench
============================================

// Module: lab2_proc_int_muldiv_iter
// PURPOSE
//  Parametrised iterative integer multiply/divide unit for the 5-stage pipelined processor.
//  Executes in X stage alongside the ALU; covers the full RV32M-style op set.
//  Uses val/rdy request and response interfaces; one operation in flight.
//  Shift-add multiply and restoring divide: one result bit per cycle.
// PARAMETERS
//  p_nbits   32  operand/result width, >=8, even
// PORTS
//  clk        in   1            clock; all state updates on posedge
//  reset      in   1            synchronous, active-high
//  req_val    in   1            request valid
//  req_rdy    out  1            request ready
//  req_fn     in   3            op: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  req_a      in   p_nbits      operand a (rs1)
//  req_b      in   p_nbits      operand b (rs2)
//  resp_val   out  1            response valid
//  resp_rdy   in   1            response ready
//  resp_msg   out  p_nbits      result
// BEHAVIOUR
//  - Reset: state=IDLE, req_rdy=1, resp_val=0, resp_msg=0, counter=0. Reset in any state aborts the op.
//  - FSM IDLE->CALC on req_val&&req_rdy; CALC->DONE when counter==p_nbits-1; DONE->IDLE on resp_val&&resp_rdy.
//  - req_rdy=1 only in IDLE; resp_val=1 only in DONE. No accept in the DONE-exit cycle.
//  - Accept cycle latches fn, sign flags and operand magnitudes. Signed ops take |x|; MULHSU treats b as unsigned.
//  - MUL*: 2*p_nbits accumulator; each CALC cycle adds a<<i if b[i]. Product negated on sign mismatch.
//    MUL returns low half; MULH/MULHSU/MULHU return high half.
//  - DIV*/REM*: restoring; remainder shifts left by 1, then subtract |b| if no borrow; quotient bit set.
//    Quotient sign = sa^sb; remainder sign = sa.
//  - Latency: accept at cycle 0; CALC in cycles 1..p_nbits; resp_val at cycle p_nbits+1 (33 for default).
//  - Divide by zero, no exception: DIV/DIVU -> all ones; REM/REMU -> a.
//  - Overflow DIV MIN/-1 -> MIN; REM MIN/-1 -> 0. Produced by the general datapath; results checked.
//  - resp_msg is held stable while resp_val=1 and resp_rdy=0. Inputs are ignored outside IDLE.
//  - Counter is log2(p_nbits) bits and wraps to 0 on CALC exit.
// CONFIGURATION
//  LAB2_PROC_MULDIV_EARLY_TERM_EN
//   - defined: MUL* leaves CALC as soon as the remaining shifted multiplier is zero.
//     Minimum 1 CALC cycle, so b=0 gives resp_val at cycle 2.
//     Divide timing is unchanged. Results are identical.
//   - undefined: fixed p_nbits CALC cycles for every op.
// STRUCTURE
//  - Package lab2_proc_muldiv_pkg:
//     fn encoding constants (MULDIV_FN_MUL..MULDIV_FN_REMU).
//     FSM state typedef {IDLE, CALC, DONE}.
//     Helper function is_signed_a/is_signed_b(fn).
//  - Sub-module lab2_proc_muldiv_sign_fix (combinational):
//     Inputs: magnitude result, sign flags, fn.
//     Outputs: final signed result, including div-by-zero override.
//  - Control FSM and datapath registers live in this module.
// TESTING (p_nbits=32)
//  - MUL a=7, b=-3 -> resp 0xFFFFFFEB at cycle 33 (no EN); with EN, MUL b=3 -> resp 21 at cycle 3.
//  - MULH a=0x80000000, b=0x80000000 -> 0x40000000.
//    MULHU a=0xFFFFFFFF, b=2 -> 1.
//    MULHSU a=-1, b=2 -> 0xFFFFFFFF.
//  - DIV a=-7, b=2 -> -3; REM -> -1. DIVU a=0x80000000, b=0 -> 0xFFFFFFFF; REMU -> 0x80000000.
//  - DIV a=0x80000000, b=-1 -> 0x80000000; REM -> 0.
//  - Backpressure: hold resp_rdy=0 for 5 cycles after resp_val.
//    resp_msg stable, req_rdy=0; after pop, next req accepted the following cycle.
//  - Reset asserted mid-CALC (cycle 10) -> next cycle IDLE, resp_val=0, req_rdy=1; fresh op then correct.

Source files
------------

// File: rtl/lab2_proc_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: function codes,
// control state encoding and operand signedness helpers.
package lab2_proc_muldiv_pkg;

  localparam logic [2:0] MULDIV_FN_MUL    = 3'd0;
  localparam logic [2:0] MULDIV_FN_MULH   = 3'd1;
  localparam logic [2:0] MULDIV_FN_MULHSU = 3'd2;
  localparam logic [2:0] MULDIV_FN_MULHU  = 3'd3;
  localparam logic [2:0] MULDIV_FN_DIV    = 3'd4;
  localparam logic [2:0] MULDIV_FN_DIVU   = 3'd5;
  localparam logic [2:0] MULDIV_FN_REM    = 3'd6;
  localparam logic [2:0] MULDIV_FN_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } muldiv_state_e;

  // Operand a is treated as two's complement for these ops.
  function automatic logic is_signed_a(input logic [2:0] fn);
    return (fn == MULDIV_FN_MUL)    || (fn == MULDIV_FN_MULH) ||
           (fn == MULDIV_FN_MULHSU) || (fn == MULDIV_FN_DIV)  ||
           (fn == MULDIV_FN_REM);
  endfunction

  // Operand b is treated as two's complement for these ops (MULHSU keeps b unsigned).
  function automatic logic is_signed_b(input logic [2:0] fn);
    return (fn == MULDIV_FN_MUL) || (fn == MULDIV_FN_MULH) ||
           (fn == MULDIV_FN_DIV) || (fn == MULDIV_FN_REM);
  endfunction

  // Multiply family occupies codes 0..3.
  function automatic logic is_mul(input logic [2:0] fn);
    return ~fn[2];
  endfunction

endpackage

// File: rtl/lab2_proc_int_muldiv_iter_if.sv
// Request/response val/rdy bundle for the iterative multiply/divide unit.
interface lab2_proc_int_muldiv_iter_if #(
  parameter int unsigned p_nbits = 32
) ();

  logic               req_val;
  logic               req_rdy;
  logic [2:0]         req_fn;
  logic [p_nbits-1:0] req_a;
  logic [p_nbits-1:0] req_b;
  logic               resp_val;
  logic               resp_rdy;
  logic [p_nbits-1:0] resp_msg;

  modport master (
    output req_val, req_fn, req_a, req_b, resp_rdy,
    input  req_rdy, resp_val, resp_msg
  );

  modport slave (
    input  req_val, req_fn, req_a, req_b, resp_rdy,
    output req_rdy, resp_val, resp_msg
  );

endinterface

// File: rtl/lab2_proc_muldiv_sign_fix.sv
// Turns the unsigned magnitude result of the iterative datapath into the final
// signed result for the selected op, including the divide-by-zero quotient.
module lab2_proc_muldiv_sign_fix
  import lab2_proc_muldiv_pkg::*;
#(
  parameter int unsigned p_nbits = 32
) (
  input  logic [2*p_nbits-1:0] mag_i,         // mul: product; div: {rem, quo}
  input  logic                 sa_i,
  input  logic                 sb_i,
  input  logic                 div_by_zero_i,
  input  logic [2:0]           fn_i,
  output logic [p_nbits-1:0]   result_o
);

  logic [2*p_nbits-1:0] prod;
  logic [p_nbits-1:0]   quo;
  logic [p_nbits-1:0]   rem;

  // Apply sign to product/quotient/remainder and select the requested field.
  always_comb begin
    prod = (sa_i ^ sb_i) ? -mag_i : mag_i;
    quo  = mag_i[p_nbits-1:0];
    rem  = mag_i[2*p_nbits-1:p_nbits];
    case (fn_i)
      MULDIV_FN_MUL:    result_o = prod[p_nbits-1:0];
      MULDIV_FN_MULH,
      MULDIV_FN_MULHSU,
      MULDIV_FN_MULHU:  result_o = prod[2*p_nbits-1:p_nbits];
      MULDIV_FN_DIV,
      MULDIV_FN_DIVU: begin
        // Quotient sign would be wrong for negative a over zero; force all ones.
        if (div_by_zero_i) result_o = '1;
        else               result_o = (sa_i ^ sb_i) ? -quo : quo;
      end
      // Remainder of x/0 is |a| signed by a, which reproduces a.
      default:          result_o = sa_i ? -rem : rem;
    endcase
  end

endmodule

// File: rtl/lab2_proc_int_muldiv_iter.sv
// Iterative integer multiply/divide unit (shift-add multiply, restoring divide),
// one result bit per cycle, one operation in flight.
// Build option LAB2_PROC_MULDIV_EARLY_TERM_EN: multiplies leave CALC as soon as the
// remaining multiplier bits are zero (at least one CALC cycle).
module lab2_proc_int_muldiv_iter
  import lab2_proc_muldiv_pkg::*;
#(
  parameter int unsigned p_nbits = 32
) (
  input logic                        clk,
  input logic                        reset,
  lab2_proc_int_muldiv_iter_if.slave io
);

  localparam int unsigned CntW = $clog2(p_nbits);
  localparam int unsigned AccW = 2 * p_nbits;

  muldiv_state_e state_q, state_d;

  logic [2:0]         fn_q, fn_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               dbz_q, dbz_d;
  logic [AccW-1:0]    acc_q, acc_d;     // mul: partial product; div: {rem, quo}
  logic [AccW-1:0]    a_sh_q, a_sh_d;   // multiplicand shifted left each cycle
  logic [p_nbits-1:0] b_sh_q, b_sh_d;   // mul: multiplier shifted right; div: |b|
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic               calc_last;
  logic               in_sa, in_sb;
  logic [p_nbits-1:0] in_a_mag, in_b_mag;
  logic [p_nbits:0]   trial;
  logic               no_borrow;
  logic [p_nbits-1:0] rem_sub;
  logic [p_nbits-1:0] fix_result;

  lab2_proc_muldiv_sign_fix #(
    .p_nbits(p_nbits)
  ) u_sign_fix (
    .mag_i        (acc_q),
    .sa_i         (sa_q),
    .sb_i         (sb_q),
    .div_by_zero_i(dbz_q),
    .fn_i         (fn_q),
    .result_o     (fix_result)
  );

  // Decide whether the current CALC cycle is the last one.
  always_comb begin
    calc_last = (cnt_q == CntW'(p_nbits - 1));
`ifdef LAB2_PROC_MULDIV_EARLY_TERM_EN
    if (is_mul(fn_q) && ((b_sh_q >> 1) == '0)) calc_last = 1'b1;
`else
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io.req_val)   state_d = CALC;
      CALC:    if (calc_last)    state_d = DONE;
      DONE:    if (io.resp_rdy)  state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Handshake outputs; the result is only driven while it is valid.
  always_comb begin
    io.req_rdy  = (state_q == IDLE);
    io.resp_val = (state_q == DONE);
    io.resp_msg = (state_q == DONE) ? fix_result : '0;
  end

  // Datapath next-state: operand capture on accept, one shift/add or
  // shift/subtract step per CALC cycle, hold otherwise.
  always_comb begin
    in_sa    = is_signed_a(io.req_fn) & io.req_a[p_nbits-1];
    in_sb    = is_signed_b(io.req_fn) & io.req_b[p_nbits-1];
    in_a_mag = in_sa ? -io.req_a : io.req_a;
    in_b_mag = in_sb ? -io.req_b : io.req_b;

    // Remainder shifted left with the next dividend bit brought in.
    trial     = {acc_q[AccW-1:p_nbits], acc_q[p_nbits-1]};
    no_borrow = (trial >= {1'b0, b_sh_q});
    rem_sub   = trial[p_nbits-1:0] - b_sh_q;

    fn_d   = fn_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    dbz_d  = dbz_q;
    acc_d  = acc_q;
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    cnt_d  = cnt_q;

    case (state_q)
      IDLE: begin
        if (io.req_val) begin
          fn_d   = io.req_fn;
          sa_d   = in_sa;
          sb_d   = in_sb;
          dbz_d  = (io.req_b == '0);
          b_sh_d = in_b_mag;
          cnt_d  = '0;
          if (is_mul(io.req_fn)) begin
            acc_d  = '0;
            a_sh_d = {{p_nbits{1'b0}}, in_a_mag};
          end else begin
            acc_d  = {{p_nbits{1'b0}}, in_a_mag};
            a_sh_d = '0;
          end
        end
      end
      CALC: begin
        if (is_mul(fn_q)) begin
          if (b_sh_q[0]) acc_d = acc_q + a_sh_q;
          a_sh_d = a_sh_q << 1;
          b_sh_d = b_sh_q >> 1;
        end else if (no_borrow) begin
          acc_d = {rem_sub, acc_q[p_nbits-2:0], 1'b1};
        end else begin
          acc_d = {trial[p_nbits-1:0], acc_q[p_nbits-2:0], 1'b0};
        end
        cnt_d = calc_last ? '0 : cnt_q + CntW'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fn_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      dbz_q  <= 1'b0;
      acc_q  <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      cnt_q  <= '0;
    end else begin
      fn_q   <= fn_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      dbz_q  <= dbz_d;
      acc_q  <= acc_d;
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lab2_proc_int_muldiv_iter.sv
// Self-checking bench for lab2_proc_int_muldiv_iter (p_nbits = 32).
module tb_lab2_proc_int_muldiv_iter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  lab2_proc_int_muldiv_iter_if #(.p_nbits(32)) bus ();

  lab2_proc_int_muldiv_iter #(
    .p_nbits(32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  // Reference: RV32M semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
    longint                as_l;
    longint                bs_l;
    longint                bu_l;
    longint unsigned       au_l;
    longint unsigned       bu_u;
    logic [63:0]           w;
    as_l = longint'($signed(a));
    bs_l = longint'($signed(b));
    bu_l = {32'b0, b};
    au_l = {32'b0, a};
    bu_u = {32'b0, b};
    case (fn)
      3'd0: begin w = as_l * bs_l; return w[31:0]; end
      3'd1: begin w = as_l * bs_l; return w[63:32]; end
      3'd2: begin w = as_l * bu_l; return w[63:32]; end
      3'd3: begin w = au_l * bu_u; return w[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        w = as_l / bs_l;
        return w[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        w = as_l % bs_l;
        return w[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Expected cycle (counted from the accept cycle) at which resp_val is first seen.
  function automatic int exp_lat(input logic [2:0] fn, input logic [31:0] b);
`ifdef LAB2_PROC_MULDIV_EARLY_TERM_EN
    logic [31:0] m;
    int          n;
    if (fn < 3'd4) begin
      m = ((fn == 3'd0 || fn == 3'd1) && b[31]) ? -b : b;
      n = 1;
      while (n < 32 && (m >> n) != 32'd0) n++;
      return n + 1;
    end
`else
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, wait (bounded) for the response, pop it. Ends on a negedge in IDLE.
  task automatic do_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!bus.req_rdy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.req_val = 1'b1;
    bus.req_fn  = fn;
    bus.req_a   = a;
    bus.req_b   = b;
    @(negedge clk);
    bus.req_val = 1'b0;
    bus.req_fn  = 3'($urandom);
    bus.req_a   = $urandom;
    bus.req_b   = $urandom;
    lat = 1;
    while (!bus.resp_val && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = bus.resp_msg;
    bus.resp_rdy = 1'b1;
    @(negedge clk);
    bus.resp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.req_val  = 1'b0;
    bus.req_fn   = 3'd0;
    bus.req_a    = 32'd0;
    bus.req_b    = 32'd0;
    bus.resp_rdy = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.req_rdy !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_rdy: got %b expected 1", bus.req_rdy);
    end
    n_checks++;
    if (bus.resp_val !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp_val: got %b expected 0", bus.resp_val);
    end
    n_checks++;
    if (bus.resp_msg !== 32'd0) begin
      n_fail++; $display("FAIL reset_resp_msg: got %h expected 0", bus.resp_msg);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.req_rdy !== 1'b1 || bus.resp_val !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got rdy=%b val=%b expected rdy=1 val=0",
               bus.req_rdy, bus.resp_val);
    end
  endtask

  task automatic test_directed();
    vec_t        v[$];
    logic [31:0] res;
    int          lat;
    v.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
    v.push_back('{3'd0, 32'd7,          32'd3,         32'd21});
    v.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
    v.push_back('{3'd3, 32'hFFFF_FFFF,  32'd2,         32'd1});
    v.push_back('{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF});
    v.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
    v.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
    v.push_back('{3'd5, 32'h8000_0000,  32'd0,         32'hFFFF_FFFF});
    v.push_back('{3'd7, 32'h8000_0000,  32'd0,         32'h8000_0000});
    v.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
    v.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0});
    v.push_back('{3'd4, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF});
    v.push_back('{3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB});
    v.push_back('{3'd0, 32'h1234_5678,  32'd0,         32'd0});
    foreach (v[i]) begin
      do_op(v[i].fn, v[i].a, v[i].b, res, lat);
      n_checks++;
      if (res !== v[i].exp) begin
        n_fail++;
        $display("FAIL directed_result[%0d] fn=%0d a=%h b=%h: got %h expected %h",
                 i, v[i].fn, v[i].a, v[i].b, res, v[i].exp);
      end
      n_checks++;
      if (lat != exp_lat(v[i].fn, v[i].b)) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d expected %0d",
                 i, lat, exp_lat(v[i].fn, v[i].b));
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  fn;
    logic [31:0] a, b, res, exp;
    int          lat;
    for (int k = 0; k < 40; k++) begin
      fn  = 3'($urandom_range(0, 7));
      a   = pick_operand();
      b   = pick_operand();
      exp = ref_model(fn, a, b);
      do_op(fn, a, b, res, lat);
      n_checks++;
      if (res !== exp) begin
        n_fail++;
        $display("FAIL random_result fn=%0d a=%h b=%h: got %h expected %h", fn, a, b, res, exp);
      end
      n_checks++;
      if (lat != exp_lat(fn, b)) begin
        n_fail++;
        $display("FAIL random_latency fn=%0d b=%h: got %0d expected %0d",
                 fn, b, lat, exp_lat(fn, b));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a1, b1, exp1, a2, b2, exp2;
    int          lat;
    a1   = $urandom;
    b1   = 32'($urandom_range(1, 1000));
    exp1 = ref_model(3'd5, a1, b1);
    a2   = $urandom;
    b2   = $urandom;
    exp2 = ref_model(3'd1, a2, b2);
    @(negedge clk);
    bus.req_val = 1'b1;
    bus.req_fn  = 3'd5;
    bus.req_a   = a1;
    bus.req_b   = b1;
    @(negedge clk);
    bus.req_val = 1'b0;
    lat = 1;
    while (!bus.resp_val && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 33) begin
      n_fail++; $display("FAIL bp_latency: got %0d expected 33", lat);
    end
    // Next request is already pending while the response is held.
    bus.req_val = 1'b1;
    bus.req_fn  = 3'd1;
    bus.req_a   = a2;
    bus.req_b   = b2;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.resp_msg !== exp1 || bus.resp_val !== 1'b1 || bus.req_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got msg=%h val=%b rdy=%b expected msg=%h val=1 rdy=0",
                 i, bus.resp_msg, bus.resp_val, bus.req_rdy, exp1);
      end
      @(negedge clk);
    end
    bus.resp_rdy = 1'b1;
    @(negedge clk);
    bus.resp_rdy = 1'b0;
    n_checks++;
    if (bus.req_rdy !== 1'b1 || bus.resp_val !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_after_pop: got rdy=%b val=%b expected rdy=1 val=0",
               bus.req_rdy, bus.resp_val);
    end
    @(negedge clk);
    bus.req_val = 1'b0;
    lat = 1;
    while (!bus.resp_val && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (bus.resp_msg !== exp2) begin
      n_fail++; $display("FAIL bp_next_result: got %h expected %h", bus.resp_msg, exp2);
    end
    n_checks++;
    if (lat != exp_lat(3'd1, b2)) begin
      n_fail++; $display("FAIL bp_next_latency: got %0d expected %0d", lat, exp_lat(3'd1, b2));
    end
    bus.resp_rdy = 1'b1;
    @(negedge clk);
    bus.resp_rdy = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] res, a, b, exp;
    int          lat;
    @(negedge clk);
    bus.req_val = 1'b1;
    bus.req_fn  = 3'd4;
    bus.req_a   = $urandom;
    bus.req_b   = $urandom;
    @(negedge clk);
    bus.req_val = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (bus.req_rdy !== 1'b1 || bus.resp_val !== 1'b0 || bus.resp_msg !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_calc_reset: got rdy=%b val=%b msg=%h expected rdy=1 val=0 msg=0",
               bus.req_rdy, bus.resp_val, bus.resp_msg);
    end
    a   = 32'hFFFF_FF9C;
    b   = 32'd7;
    exp = ref_model(3'd6, a, b);
    do_op(3'd6, a, b, res, lat);
    n_checks++;
    if (res !== exp) begin
      n_fail++; $display("FAIL after_reset_result: got %h expected %h", res, exp);
    end
    n_checks++;
    if (lat != 33) begin
      n_fail++; $display("FAIL after_reset_latency: got %0d expected 33", lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  fn;
    logic [31:0] a, b, exp;
    int          lat;
    bus.resp_rdy = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (bus.req_rdy !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", k, bus.req_rdy);
      end
      fn  = 3'($urandom_range(0, 7));
      a   = pick_operand();
      b   = pick_operand();
      exp = ref_model(fn, a, b);
      bus.req_val = 1'b1;
      bus.req_fn  = fn;
      bus.req_a   = a;
      bus.req_b   = b;
      @(negedge clk);
      bus.req_val = 1'b0;
      lat = 1;
      while (!bus.resp_val && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      n_checks++;
      if (bus.resp_msg !== exp) begin
        n_fail++;
        $display("FAIL b2b_result fn=%0d a=%h b=%h: got %h expected %h",
                 fn, a, b, bus.resp_msg, exp);
      end
      n_checks++;
      if (lat != exp_lat(fn, b)) begin
        n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", lat, exp_lat(fn, b));
      end
      @(negedge clk);
    end
    bus.resp_rdy = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
